iobuf_bank: RTL and testbench
=============================

Name: iobuf_bank

Overview:
- Parametrised, multi-channel successor to the single-pin IO buffer controller.
- Drives CH external level-shifting buffers: direction pin, open-drain mode pin, and the FPGA-side tristate (oe/dout/din) that connects to SB_IO cells instantiated in the top module.
- Adds a contention-free direction turnaround sequencer, per-channel open-drain emulation, a bank-wide safe-disable, and a synchronised, glitch-filtered input path.
- Sits between the protocol engines (SPI/I2C/UART) and the top-level SB_IO instances.

Parameters:
- CH, 8, number of IO channels.
- SETTLE_CYCLES, 4, clocks between buf_dir asserting and pin_oe first asserting (input→output turnaround). Must be ≥1.
- TURN_CYCLES, 2, clocks between pin_oe releasing and buf_dir deasserting (output→input turnaround). Must be ≥1.
- FILTER_LEN, 2, consecutive stable samples required before ch_din changes. 0 disables the filter.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- bank_en  in  1  0 forces every channel toward input via the normal turnaround.
- ch_dir  in  CH  requested direction: 1 = output, 0 = input.
- ch_od  in  CH  1 = open-drain output mode.
- ch_dout  in  CH  data to drive.
- ch_din  out  CH  synchronised, filtered pin data.
- ch_ready  out  CH  1 = channel is settled in its requested direction.
- buf_dir  out  CH  external buffer direction: 1 = toward connector.
- buf_od  out  CH  external buffer open-drain select.
- pin_oe  out  CH  to SB_IO OUTPUT_ENABLE.
- pin_dout  out  CH  to SB_IO D_OUT_0.
- pin_din  in  CH  from SB_IO D_IN_0 (asynchronous).

Behaviour:
- All outputs are registered. On reset: buf_dir, buf_od, pin_oe, pin_dout, ch_din, ch_ready = 0; every channel is in state IN; counters and synchronisers are cleared. Reset may assert at any time and takes effect immediately, including mid-turnaround.
- Effective request per channel: req = ch_dir & bank_en.
- Per-channel FSM (channels are fully independent):
  - IN: buf_dir=0, pin_oe=0. If req=1, go to TURN_OUT: buf_dir=1 on the same edge, counter loaded with SETTLE_CYCLES.
  - TURN_OUT: buf_dir=1, pin_oe=0. Counter decrements each clock. At 0, go to OUT.
  - OUT: buf_dir=1, with drive per the output rules below. If req=0, go to TURN_IN: pin_oe=0 on the same edge, counter loaded with TURN_CYCLES.
  - TURN_IN: buf_dir=1, pin_oe=0. Counter decrements each clock. At 0, go to IN: buf_dir=0.
- Timing contracts:
  - pin_oe first asserts exactly SETTLE_CYCLES+1 edges after buf_dir rises.
  - buf_dir falls exactly TURN_CYCLES+1 edges after pin_oe falls.
  - pin_oe and buf_dir never disagree with the buffer direction, so there is no bus contention.
- req is sampled only in IN and OUT. TURN_* states always complete, after which req is re-evaluated. A request that reverts during a turnaround therefore causes a full round trip.
- Output rules (OUT state), one-cycle latency from ch_dout/ch_od to the pins:
  - ch_od=0: pin_oe=1, pin_dout=ch_dout, buf_od=0.
  - ch_od=1: pin_dout=0, pin_oe=~ch_dout, buf_od=1. The channel drives low only; high is released to the pull-up.
  - Outside OUT: buf_od is held at its last value; pin_dout=0.
- ch_ready = (state==IN & !req) | (state==OUT & req), registered.
- Input path (active in all states, so loopback is visible):
  - pin_din passes through a 2-flop synchroniser.
  - FILTER_LEN=0: ch_din follows the second sync stage on the next edge. A stable pin change appears on ch_din 3 edges after the first sampling edge.
  - FILTER_LEN=F>0: ch_din updates only after the sync output has differed from ch_din for F consecutive clocks, giving latency 3+F edges. Any reversion clears the count.
- Counter widths: $clog2(max(SETTLE_CYCLES, TURN_CYCLES, FILTER_LEN)+1).

Decomposition:
- Package iobuf_pkg:
  - state encoding (IN, TURN_OUT, OUT, TURN_IN);
  - DIR_IN/DIR_OUT constants;
  - the counter-width function.
- Sub-module iobuf_chan: one channel's FSM, output logic and input filter.
- iobuf_bank contains a generate loop instantiating CH copies of iobuf_chan. SB_IO instances remain in the top module.

Test Plan:
- Reset then idle, with all inputs 0 → all outputs 0; ch_ready=1 on the first edge after reset release, and stays 1.
- ch_dir[0]=1, bank_en=1, SETTLE=4 → buf_dir[0] rises at edge E; pin_oe[0] rises at E+5; ch_ready[0] rises at E+6. Channels 1–7 are unchanged throughout.
- From OUT, drop ch_dir[0], TURN=2 → pin_oe[0] falls at edge E; buf_dir[0] falls at E+3. pin_oe and buf_dir are never 1/0 respectively in the same cycle.
- Open-drain, ch_od[3]=1, ch_dout[3] toggling 1,0,1 → pin_oe[3] goes 0,1,0 (one cycle late), pin_dout[3] is constant 0, buf_od[3]=1.
- FILTER_LEN=2: a 1-cycle pulse on pin_din[5] → ch_din[5] stays 0. A stable rise on pin_din[5] → ch_din[5] rises exactly 5 edges later.
- bank_en dropped with all channels in OUT → all channels run TURN_IN in parallel and reach IN. Asserting reset_n=0 mid TURN_OUT clears all outputs immediately (asynchronously).

Source files
------------

// File: rtl/iobuf_pkg.sv
// iobuf_pkg: shared types and helpers for the IO buffer bank.
// Channel state encoding, direction constants, counter sizing.
package iobuf_pkg;

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } ch_state_e;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iobuf_chan.sv
// iobuf_chan: one IO channel with direction turnaround sequencing,
// open-drain emulation and a synchronised, glitch-filtered input.
module iobuf_chan
  import iobuf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TURN_CYCLES   = 2,
  parameter int FILTER_LEN    = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic od,
  input  logic dout,
  input  logic pin_din,
  output logic din,
  output logic ready,
  output logic buf_dir,
  output logic buf_od,
  output logic pin_oe,
  output logic pin_dout
);

  localparam int CW = cnt_width(SETTLE_CYCLES, TURN_CYCLES, FILTER_LEN);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] FLT_LD    = CW'(FILTER_LEN);
  localparam logic [CW-1:0] ONE       = CW'(1);

  ch_state_e       state_q;
  ch_state_e       state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic            dir_d;
  logic            oe_d;
  logic            dout_d;
  logic            bod_d;
  logic            ready_d;

  logic [1:0]      sync_q;
  logic [CW-1:0]   flt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Turnarounds always run to completion; req is only looked at in IN/OUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IN: begin
        if (req) begin
          state_d = ST_TURN_OUT;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_TURN_OUT: begin
        if (cnt_q == '0) state_d = ST_OUT;
        else             cnt_d   = cnt_q - ONE;
      end
      ST_OUT: begin
        if (!req) begin
          state_d = ST_TURN_IN;
          cnt_d   = TURN_LD;
        end
      end
      ST_TURN_IN: begin
        if (cnt_q == '0) state_d = ST_IN;
        else             cnt_d   = cnt_q - ONE;
      end
    endcase
  end

  always_comb begin
    dir_d   = (state_d != ST_IN) ? DIR_OUT : DIR_IN;
    oe_d    = 1'b0;
    dout_d  = 1'b0;
    bod_d   = buf_od;
    ready_d = ((state_q == ST_IN) && !req) ||
              ((state_q == ST_OUT) && req);
    if (state_d == ST_OUT) begin
      bod_d = od;
      unique case (1'b1)
        od: begin
          oe_d   = ~dout;
          dout_d = 1'b0;
        end
        !od: begin
          oe_d   = 1'b1;
          dout_d = dout;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_dir  <= DIR_IN;
      buf_od   <= 1'b0;
      pin_oe   <= 1'b0;
      pin_dout <= 1'b0;
      ready    <= 1'b0;
    end else begin
      buf_dir  <= dir_d;
      buf_od   <= bod_d;
      pin_oe   <= oe_d;
      pin_dout <= dout_d;
      ready    <= ready_d;
    end
  end

  // din moves only once the synced pin has disagreed for FILTER_LEN clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      flt_q  <= '0;
      din    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_din};
      if (sync_q[1] != din) begin
        if (flt_q == FLT_LD) begin
          din   <= sync_q[1];
          flt_q <= '0;
        end else begin
          flt_q <= flt_q + ONE;
        end
      end else begin
        flt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/iobuf_bank.sv
// iobuf_bank: CH independent IO buffer channels with a bank-wide
// enable that walks every channel back to input.
module iobuf_bank
  import iobuf_pkg::*;
#(
  parameter int CH            = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int TURN_CYCLES   = 2,
  parameter int FILTER_LEN    = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          bank_en,
  input  logic [CH-1:0] ch_dir,
  input  logic [CH-1:0] ch_od,
  input  logic [CH-1:0] ch_dout,
  output logic [CH-1:0] ch_din,
  output logic [CH-1:0] ch_ready,
  output logic [CH-1:0] buf_dir,
  output logic [CH-1:0] buf_od,
  output logic [CH-1:0] pin_oe,
  output logic [CH-1:0] pin_dout,
  input  logic [CH-1:0] pin_din
);

  logic [CH-1:0] req;

  assign req = ch_dir & {CH{bank_en}};

  for (genvar i = 0; i < CH; i++) begin : g_ch
    iobuf_chan #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .TURN_CYCLES   (TURN_CYCLES),
      .FILTER_LEN    (FILTER_LEN)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .req      (req[i]),
      .od       (ch_od[i]),
      .dout     (ch_dout[i]),
      .pin_din  (pin_din[i]),
      .din      (ch_din[i]),
      .ready    (ch_ready[i]),
      .buf_dir  (buf_dir[i]),
      .buf_od   (buf_od[i]),
      .pin_oe   (pin_oe[i]),
      .pin_dout (pin_dout[i])
    );
  end

endmodule

// File: tb/tb_iobuf_bank.sv
// tb_iobuf_bank: directed bench for the IO buffer bank.
// Table-driven steady-state vectors plus hand-written turnaround sequences.
module tb_iobuf_bank;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       bank_en = 1'b0;
  logic [7:0] ch_dir = '0;
  logic [7:0] ch_od = '0;
  logic [7:0] ch_dout = '0;
  logic [7:0] pin_din = '0;
  logic [7:0] ch_din;
  logic [7:0] ch_ready;
  logic [7:0] buf_dir;
  logic [7:0] buf_od;
  logic [7:0] pin_oe;
  logic [7:0] pin_dout;

  int checks = 0;
  int failures = 0;

  iobuf_bank #(
    .CH            (8),
    .SETTLE_CYCLES (4),
    .TURN_CYCLES   (2),
    .FILTER_LEN    (2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bank_en  (bank_en),
    .ch_dir   (ch_dir),
    .ch_od    (ch_od),
    .ch_dout  (ch_dout),
    .ch_din   (ch_din),
    .ch_ready (ch_ready),
    .buf_dir  (buf_dir),
    .buf_od   (buf_od),
    .pin_oe   (pin_oe),
    .pin_dout (pin_dout),
    .pin_din  (pin_din)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       en;
    logic [7:0] dir;
    logic [7:0] od;
    logic [7:0] dout;
    int         waits;
    logic [7:0] e_dir;
    logic [7:0] e_oe;
    logic [7:0] e_dout;
    logic [7:0] e_bod;
    logic [7:0] e_rdy;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if ((pin_oe & ~buf_dir) != 8'h00) begin
        failures++;
        $display("FAIL contention: pin_oe %h buf_dir %h", pin_oe, buf_dir);
      end
    end
  end

  initial begin
    vt[0]  = '{"all_out",   1'b1, 8'hff, 8'h00, 8'ha5, 7,
               8'hff, 8'hff, 8'ha5, 8'h00, 8'hff};
    vt[1]  = '{"dout_lat",  1'b1, 8'hff, 8'h00, 8'h3c, 1,
               8'hff, 8'hff, 8'h3c, 8'h00, 8'hff};
    vt[2]  = '{"od_mix",    1'b1, 8'hff, 8'hf0, 8'h3c, 1,
               8'hff, 8'hcf, 8'h0c, 8'hf0, 8'hff};
    vt[3]  = '{"od_high",   1'b1, 8'hff, 8'hf0, 8'hff, 1,
               8'hff, 8'h0f, 8'h0f, 8'hf0, 8'hff};
    vt[4]  = '{"bank_off",  1'b0, 8'hff, 8'hf0, 8'hff, 4,
               8'h00, 8'h00, 8'h00, 8'hf0, 8'h00};
    vt[5]  = '{"bank_rdy",  1'b0, 8'hff, 8'hf0, 8'hff, 1,
               8'h00, 8'h00, 8'h00, 8'hf0, 8'hff};
    vt[6]  = '{"lo_turn",   1'b1, 8'h0f, 8'h00, 8'hff, 1,
               8'h0f, 8'h00, 8'h00, 8'hf0, 8'hf0};
    vt[7]  = '{"lo_out",    1'b1, 8'h0f, 8'h00, 8'hff, 5,
               8'h0f, 8'h0f, 8'h0f, 8'hf0, 8'hf0};
    vt[8]  = '{"lo_rdy",    1'b1, 8'h0f, 8'h00, 8'hff, 1,
               8'h0f, 8'h0f, 8'h0f, 8'hf0, 8'hff};
    vt[9]  = '{"lo_in",     1'b1, 8'h00, 8'h00, 8'hff, 4,
               8'h00, 8'h00, 8'h00, 8'hf0, 8'hf0};
    vt[10] = '{"lo_in_rdy", 1'b1, 8'h00, 8'h00, 8'hff, 1,
               8'h00, 8'h00, 8'h00, 8'hf0, 8'hff};

    // reset state, async
    #2;
    chk("rst_buf_dir", buf_dir, 8'h00);
    chk("rst_pin_oe", pin_oe, 8'h00);
    chk("rst_pin_dout", pin_dout, 8'h00);
    chk("rst_buf_od", buf_od, 8'h00);
    chk("rst_ch_din", ch_din, 8'h00);
    chk("rst_ready", ch_ready, 8'h00);
    #10;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_ready", ch_ready, 8'hff);
      chk("idle_buf_dir", buf_dir, 8'h00);
      chk("idle_pin_oe", pin_oe, 8'h00);
    end

    // ch0 input -> output
    bank_en = 1'b1;
    ch_dir  = 8'h01;
    ch_dout = 8'h01;
    tick();
    chk("to_out_E_dir", buf_dir, 8'h01);
    chk("to_out_E_oe", pin_oe, 8'h00);
    chk("to_out_E_rdy", ch_ready, 8'hfe);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("to_out_dir", buf_dir, 8'h01);
      chk("to_out_oe", pin_oe, (k >= 5) ? 8'h01 : 8'h00);
      chk("to_out_dout", pin_dout, (k >= 5) ? 8'h01 : 8'h00);
      chk("to_out_rdy", ch_ready, (k >= 6) ? 8'hff : 8'hfe);
    end

    // ch0 output -> input
    ch_dir = 8'h00;
    tick();
    chk("to_in_E_oe", pin_oe, 8'h00);
    chk("to_in_E_dir", buf_dir, 8'h01);
    chk("to_in_E_rdy", ch_ready, 8'hfe);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("to_in_dir", buf_dir, (k >= 3) ? 8'h00 : 8'h01);
      chk("to_in_oe", pin_oe, 8'h00);
      chk("to_in_rdy", ch_ready, (k >= 4) ? 8'hff : 8'hfe);
    end

    // steady-state table
    for (int i = 0; i < 11; i++) begin
      bank_en = vt[i].en;
      ch_dir  = vt[i].dir;
      ch_od   = vt[i].od;
      ch_dout = vt[i].dout;
      for (int w = 0; w < vt[i].waits; w++) tick();
      chk({vt[i].name, "_buf_dir"}, buf_dir, vt[i].e_dir);
      chk({vt[i].name, "_pin_oe"}, pin_oe, vt[i].e_oe);
      chk({vt[i].name, "_pin_dout"}, pin_dout, vt[i].e_dout);
      chk({vt[i].name, "_buf_od"}, buf_od, vt[i].e_bod);
      chk({vt[i].name, "_ready"}, ch_ready, vt[i].e_rdy);
    end

    // open-drain on ch3
    bank_en = 1'b1;
    ch_dir  = 8'h08;
    ch_od   = 8'h08;
    ch_dout = 8'h08;
    for (int w = 0; w < 6; w++) tick();
    chk("od_entry_oe", pin_oe, 8'h00);
    chk("od_entry_bod", buf_od, 8'hf8);
    for (int k = 0; k < 3; k++) begin
      logic d;
      d = (k == 1) ? 1'b0 : 1'b1;
      ch_dout = {4'h0, d, 3'b000};
      #1;
      chk("od_hold_oe", pin_oe, (k == 2) ? 8'h08 : 8'h00);
      tick();
      chk("od_oe", pin_oe, d ? 8'h00 : 8'h08);
      chk("od_dout", pin_dout, 8'h00);
      chk("od_bod", buf_od, 8'hf8);
    end

    // input filter on ch5: 1-cycle glitch then a stable rise
    pin_din = 8'h20;
    tick();
    pin_din = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("glitch_din", ch_din, 8'h00);
    end
    pin_din = 8'h20;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("rise_din", ch_din, (k >= 5) ? 8'h20 : 8'h00);
    end

    // reset mid TURN_OUT
    ch_dir  = 8'hff;
    ch_od   = 8'h00;
    ch_dout = 8'h00;
    tick();
    tick();
    chk("turn_buf_dir", buf_dir, 8'hff);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_buf_dir", buf_dir, 8'h00);
    chk("arst_buf_od", buf_od, 8'h00);
    chk("arst_pin_oe", pin_oe, 8'h00);
    chk("arst_ready", ch_ready, 8'h00);
    chk("arst_ch_din", ch_din, 8'h00);
    reset_n = 1'b1;
    tick();
    chk("post_rst_dir", buf_dir, 8'hff);
    chk("post_rst_oe", pin_oe, 8'h00);
    chk("post_rst_rdy", ch_ready, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
